// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data-memory path. Accesses are serialised, round-robin arbitrated
// when both sides request, and complete a fixed MEM_LAT cycles after mem_en.
//
// Build option: define ARB_STATS_EN to add the if_cnt / dm_cnt / wait_cnt
// statistics outputs. Without it those ports and registers do not exist.
//
// state  | meaning
// IDLE   | sampling requests; winner selected and registered here
// ACCESS | one cycle that launches mem_en with the registered address/data
// WAIT   | lat_cnt counts down to 0, then read data is captured and done pulses
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       if_cnt,
  output logic [15:0]       dm_cnt,
  output logic [15:0]       wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  // ACCESS loads MEM_LAT-1 so completion lands exactly MEM_LAT cycles after
  // the mem_en cycle; MEM_LAT=1 therefore completes straight from a zero count.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       last_dm;
  logic       cur_dm;
  logic       dm_req;
  logic       pick_dm;

  assign dm_req = dm_read | dm_write;

  // Round-robin: data wins when alone, or when both request and fetch was served last.
  assign pick_dm = dm_req & (~if_req | ~last_dm);

  // Stall covers pending and in-flight accesses but drops in the done cycle
  // so the requester can advance while the arbiter is already back in IDLE.
  assign stall = (if_req | dm_req | (state != IDLE)) & ~(if_done | dm_done);

`ifdef ARB_STATS_EN
  logic loser_waiting;

  // A requester is waiting when it is active but is not the winner being served or selected.
  always_comb begin
    loser_waiting = 1'b0;
    if (state == IDLE) loser_waiting = if_req & dm_req;
    else               loser_waiting = cur_dm ? if_req : dm_req;
  end
`endif

  // Arbitration FSM with registered strobes, memory interface and read-data capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      last_dm   <= 1'b0;
      cur_dm    <= 1'b0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_STATS_EN
      if_cnt    <= '0;
      dm_cnt    <= '0;
      wait_cnt  <= '0;
`endif
    end else begin
      if_gnt  <= 1'b0;
      dm_gnt  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      mem_en  <= 1'b0;
`ifdef ARB_STATS_EN
      if (loser_waiting && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
`endif
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            cur_dm <= pick_dm;
            if (pick_dm) begin
              // read+write together is treated as a write
              mem_we    <= dm_write;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              dm_gnt    <= 1'b1;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              if_gnt    <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en  <= 1'b1;
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (cur_dm) begin
              dm_done <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
`ifdef ARB_STATS_EN
              if (dm_cnt != 16'hFFFF) dm_cnt <= dm_cnt + 16'd1;
`endif
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
`ifdef ARB_STATS_EN
              if (if_cnt != 16'hFFFF) if_cnt <= if_cnt + 16'd1;
`endif
            end
            last_dm <= cur_dm;
            state   <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 2;

  logic              CLK;
  logic              RST_N;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
`ifdef ARB_STATS_EN
  logic [15:0]       if_cnt;
  logic [15:0]       dm_cnt;
  logic [15:0]       wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
`ifdef ARB_STATS_EN
    , .if_cnt(if_cnt), .dm_cnt(dm_cnt), .wait_cnt(wait_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(if_gnt),    32'h0);
    chk({tag, "_if_done"},   32'(if_done),   32'h0);
    chk({tag, "_if_rdata"},  32'(if_rdata),  32'h0);
    chk({tag, "_dm_gnt"},    32'(dm_gnt),    32'h0);
    chk({tag, "_dm_done"},   32'(dm_done),   32'h0);
    chk({tag, "_dm_rdata"},  32'(dm_rdata),  32'h0);
    chk({tag, "_mem_en"},    32'(mem_en),    32'h0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'h0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_stall"},     32'(stall),     32'h0);
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store conflict.
  // Drives the request at a negedge (cycle T) and checks the fixed timeline
  // gnt T+1, mem_en T+2, done T+4, request dropped within the done cycle.
  task automatic run_access(input int kind, input logic [15:0] a, input logic [15:0] wd,
                            input logic [15:0] rd);
    logic is_dm;
    logic is_wr;
    is_dm = (kind != 0);
    is_wr = (kind >= 2);
    @(negedge CLK);
    mem_rdata = rd;
    if_req    = (kind == 0);
    dm_read   = (kind == 1) || (kind == 3);
    dm_write  = is_wr;
    if_addr   = a;
    dm_addr   = a;
    dm_wdata  = wd;
    @(negedge CLK);
    chk("gnt_if", 32'(if_gnt), 32'(!is_dm));
    chk("gnt_dm", 32'(dm_gnt), 32'(is_dm));
    chk("stall_pending", 32'(stall), 32'h1);
    @(negedge CLK);
    chk("mem_en_launch", 32'(mem_en), 32'h1);
    chk("mem_addr", 32'(mem_addr), 32'(a));
    chk("mem_we", 32'(mem_we), 32'(is_wr));
    if (is_wr) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
    @(negedge CLK);
    chk("mem_en_single", 32'(mem_en), 32'h0);
    chk("stall_wait", 32'(stall), 32'h1);
    @(negedge CLK);
    chk("done_if", 32'(if_done), 32'(!is_dm));
    chk("done_dm", 32'(dm_done), 32'(is_dm));
    chk("stall_done_cycle", 32'(stall), 32'h0);
    if_req   = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    @(negedge CLK);
    chk("done_single_pulse", 32'(if_done | dm_done), 32'h0);
    chk("stall_idle", 32'(stall), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin : main
    bit g_seq[$];
    int en_cyc[$];
    bit seen_done;

    RST_N     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;

    // Reset asserted while a fetch is in WAIT
    @(negedge CLK);
    mem_rdata = 16'h7777;
    if_req    = 1'b1;
    if_addr   = 16'h0040;
    @(negedge CLK);
    chk("rstmid_gnt", 32'(if_gnt), 32'h1);
    @(negedge CLK);
    chk("rstmid_mem_en", 32'(mem_en), 32'h1);
    @(negedge CLK);
    RST_N  = 1'b0;
    if_req = 1'b0;
    #1;
    chk_all_zero("rstmid");
    @(negedge CLK);
    RST_N = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (if_done || dm_done || mem_en) seen_done = 1'b1;
    end
    chk("rstmid_no_done", 32'(seen_done), 32'h0);
    chk("rstmid_idle_stall", 32'(stall), 32'h0);

    // Single fetch
    run_access(0, 16'h0004, 16'h0000, 16'h1234);
    chk("fetch_rdata", 32'(if_rdata), 32'h1234);
    chk("fetch_dm_rdata_untouched", 32'(dm_rdata), 32'h0);

    // Load
    run_access(1, 16'h0010, 16'h0000, 16'hBEEF);
    chk("load_rdata", 32'(dm_rdata), 32'hBEEF);
    chk("load_if_rdata_kept", 32'(if_rdata), 32'h1234);

    // Store
    run_access(2, 16'h0020, 16'h00AA, 16'h9999);
    chk("store_dm_rdata_kept", 32'(dm_rdata), 32'hBEEF);
    chk("store_if_rdata_kept", 32'(if_rdata), 32'h1234);

    // Read+write conflict behaves as a store
    run_access(3, 16'h0030, 16'h0055, 16'h5555);
    chk("conflict_dm_rdata_kept", 32'(dm_rdata), 32'hBEEF);

    // Contention: both held from reset release
    @(negedge CLK);
    RST_N     = 1'b0;
    if_req    = 1'b1;
    dm_read   = 1'b1;
    if_addr   = 16'h0100;
    dm_addr   = 16'h0200;
    mem_rdata = 16'h4242;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (if_gnt) g_seq.push_back(1'b0);
      if (dm_gnt) g_seq.push_back(1'b1);
      if (mem_en) en_cyc.push_back(c);
      if (if_gnt && dm_gnt) chk("contention_dual_gnt", 32'h1, 32'h0);
    end
    if_req  = 1'b0;
    dm_read = 1'b0;
    chk("contention_enough_grants", 32'(g_seq.size() >= 8), 32'h1);
    for (int i = 1; i < g_seq.size(); i++)
      chk("contention_alternate", 32'(g_seq[i]), 32'(!g_seq[i-1]));
    for (int i = 1; i < en_cyc.size(); i++)
      chk("contention_spacing", 32'(en_cyc[i] - en_cyc[i-1]), 32'(MEM_LAT + 2));
    repeat (6) @(negedge CLK);

`ifdef ARB_STATS_EN
    do_reset();
    chk("stats_reset_if", 32'(if_cnt), 32'h0);
    run_access(0, 16'h0001, 16'h0000, 16'h0101);
    run_access(1, 16'h0002, 16'h0000, 16'h0202);
    run_access(0, 16'h0003, 16'h0000, 16'h0303);
    run_access(3, 16'h0004, 16'h0044, 16'h0404);
    run_access(0, 16'h0005, 16'h0000, 16'h0505);
    chk("stats_if_cnt", 32'(if_cnt), 32'h3);
    chk("stats_dm_cnt", 32'(dm_cnt), 32'h2);
    chk("stats_wait_cnt", 32'(wait_cnt), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
